// File: rtl/ysyx_22040895_priv_seq.sv
// +----------------------------------------------------------------------------+
// | ysyx_22040895_priv_seq: serialises ECALL/MRET/CSRRW/CSRRS onto one CSR port |
// | Optional completed-op counter: YSYX_22040895_PRIV_CNT_EN.  Rev 1.0         |
// +----------------------------------------------------------------------------+
`default_nettype none

module ysyx_22040895_priv_seq #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] MCAUSE_EC = XLEN'(11)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic [XLEN-1:0] req_pc_i,
  input  logic [11:0]     req_csr_i,
  input  logic [XLEN-1:0] req_rs1_i,
  input  logic            req_rs1z_i,
  output logic [11:0]     csr_addr_o,
  output logic            csr_ren_o,
  input  logic [XLEN-1:0] csr_rdata_i,
  output logic            csr_wen_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_rd_o,
  output logic            resp_redir_o,
  output logic [XLEN-1:0] resp_pc_o,
  output logic [31:0]     priv_cnt_o
);

  localparam logic [2:0] OP_ECALL = 3'b001;
  localparam logic [2:0] OP_MRET  = 3'b010;
  localparam logic [2:0] OP_CSRRS = 3'b011;
  localparam logic [2:0] OP_CSRRW = 3'b100;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_CSR_RD    = 4'd1;
  localparam logic [3:0] S_CSR_WR    = 4'd2;
  localparam logic [3:0] S_EC_MEPC   = 4'd3;
  localparam logic [3:0] S_EC_MCAUSE = 4'd4;
  localparam logic [3:0] S_EC_MTVEC  = 4'd5;
  localparam logic [3:0] S_MR_MEPC   = 4'd6;
  localparam logic [3:0] S_MR_ST_RD  = 4'd7;
  localparam logic [3:0] S_MR_ST_WR  = 4'd8;
  localparam logic [3:0] S_RESP      = 4'd9;

  logic [3:0]      state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [11:0]     csr_q, csr_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic            rs1z_q, rs1z_d;
  logic [XLEN-1:0] old_q, old_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [XLEN-1:0] st_q, st_d;
  logic [XLEN-1:0] mret_st;
  logic            is_csr_op;
  logic            is_trap_op;

  // MRET: MPP<-0, MPIE<-1, MIE<-old MPIE
  always_comb begin
    mret_st        = st_q;
    mret_st[12:11] = 2'b00;
    mret_st[7]     = 1'b1;
    mret_st[3]     = st_q[7];
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    pc_d        = pc_q;
    csr_d       = csr_q;
    rs1_d       = rs1_q;
    rs1z_d      = rs1z_q;
    old_d       = old_q;
    tgt_d       = tgt_q;
    st_d        = st_q;
    csr_addr_o  = '0;
    csr_ren_o   = 1'b0;
    csr_wen_o   = 1'b0;
    csr_wdata_o = '0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          op_d   = req_op_i;
          pc_d   = req_pc_i;
          csr_d  = req_csr_i;
          rs1_d  = req_rs1_i;
          rs1z_d = req_rs1z_i;
          case (req_op_i)
            OP_CSRRS, OP_CSRRW: state_d = S_CSR_RD;
            OP_ECALL:           state_d = S_EC_MEPC;
            OP_MRET:            state_d = S_MR_MEPC;
            default:            state_d = S_RESP;
          endcase
        end
      end
      S_CSR_RD: begin
        csr_ren_o  = 1'b1;
        csr_addr_o = csr_q;
        old_d      = csr_rdata_i;
        state_d    = (op_q == OP_CSRRS && rs1z_q) ? S_RESP : S_CSR_WR;
      end
      S_CSR_WR: begin
        csr_wen_o   = 1'b1;
        csr_addr_o  = csr_q;
        csr_wdata_o = (op_q == OP_CSRRW) ? rs1_q : (old_q | rs1_q);
        state_d     = S_RESP;
      end
      S_EC_MEPC: begin
        csr_wen_o   = 1'b1;
        csr_addr_o  = CSR_MEPC;
        csr_wdata_o = pc_q;
        state_d     = S_EC_MCAUSE;
      end
      S_EC_MCAUSE: begin
        csr_wen_o   = 1'b1;
        csr_addr_o  = CSR_MCAUSE;
        csr_wdata_o = MCAUSE_EC;
        state_d     = S_EC_MTVEC;
      end
      S_EC_MTVEC: begin
        csr_ren_o  = 1'b1;
        csr_addr_o = CSR_MTVEC;
        tgt_d      = csr_rdata_i;
        state_d    = S_RESP;
      end
      S_MR_MEPC: begin
        csr_ren_o  = 1'b1;
        csr_addr_o = CSR_MEPC;
        tgt_d      = csr_rdata_i;
        state_d    = S_MR_ST_RD;
      end
      S_MR_ST_RD: begin
        csr_ren_o  = 1'b1;
        csr_addr_o = CSR_MSTATUS;
        st_d       = csr_rdata_i;
        state_d    = S_MR_ST_WR;
      end
      S_MR_ST_WR: begin
        csr_wen_o   = 1'b1;
        csr_addr_o  = CSR_MSTATUS;
        csr_wdata_o = mret_st;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      pc_q    <= '0;
      csr_q   <= '0;
      rs1_q   <= '0;
      rs1z_q  <= 1'b0;
      old_q   <= '0;
      tgt_q   <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pc_q    <= pc_d;
      csr_q   <= csr_d;
      rs1_q   <= rs1_d;
      rs1z_q  <= rs1z_d;
      old_q   <= old_d;
      tgt_q   <= tgt_d;
      st_q    <= st_d;
    end
  end

  assign is_csr_op    = (op_q == OP_CSRRS) || (op_q == OP_CSRRW);
  assign is_trap_op   = (op_q == OP_ECALL) || (op_q == OP_MRET);
  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_rd_o    = (resp_valid_o && is_csr_op) ? old_q : '0;
  assign resp_redir_o = resp_valid_o && is_trap_op;
  assign resp_pc_o    = resp_redir_o ? tgt_q : '0;

`ifdef YSYX_22040895_PRIV_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (resp_valid_o && resp_ready_i && (is_csr_op || is_trap_op) &&
                 (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign priv_cnt_o = cnt_q;
`else
  assign priv_cnt_o = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040895_priv_seq.sv
// Randomized bench for ysyx_22040895_priv_seq: CSR file environment, op-level
// reference model, per-cycle compare process and literal spot checks.
`default_nettype none

module tb_ysyx_22040895_priv_seq;

  localparam logic [2:0] OP_ECALL = 3'b001;
  localparam logic [2:0] OP_MRET  = 3'b010;
  localparam logic [2:0] OP_CSRRS = 3'b011;
  localparam logic [2:0] OP_CSRRW = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  req_op_i = '0;
  logic [63:0] req_pc_i = '0;
  logic [11:0] req_csr_i = '0;
  logic [63:0] req_rs1_i = '0;
  logic        req_rs1z_i = 1'b0;
  logic [11:0] csr_addr_o;
  logic        csr_ren_o;
  logic [63:0] csr_rdata_i;
  logic        csr_wen_o;
  logic [63:0] csr_wdata_o;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [63:0] resp_rd_o;
  logic        resp_redir_o;
  logic [63:0] resp_pc_o;
  logic [31:0] priv_cnt_o;

  always #5 clk = ~clk;

  ysyx_22040895_priv_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_pc_i(req_pc_i), .req_csr_i(req_csr_i), .req_rs1_i(req_rs1_i), .req_rs1z_i(req_rs1z_i),
    .csr_addr_o(csr_addr_o), .csr_ren_o(csr_ren_o), .csr_rdata_i(csr_rdata_i),
    .csr_wen_o(csr_wen_o), .csr_wdata_o(csr_wdata_o),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_rd_o(resp_rd_o),
    .resp_redir_o(resp_redir_o), .resp_pc_o(resp_pc_o), .priv_cnt_o(priv_cnt_o)
  );

  // CSR file environment with a backdoor preload port
  logic [63:0] csr_mem [0:4095];
  logic        bk_en = 1'b0;
  logic [11:0] bk_addr = '0;
  logic [63:0] bk_data = '0;
  assign csr_rdata_i = csr_mem[csr_addr_o];
  always @(posedge clk) begin
    if (csr_wen_o) csr_mem[csr_addr_o] <= csr_wdata_o;
    else if (bk_en) csr_mem[bk_addr] <= bk_data;
  end

  // Reference model state and the expected outputs for the current cycle
  logic [63:0] ref_csr [0:4095];
  logic        exp_ready, exp_ren, exp_wen, exp_rv, exp_redir;
  logic [11:0] exp_addr;
  logic [63:0] exp_wdata, exp_rd, exp_pc;
  logic [31:0] exp_cnt = '0;
  logic        m_ren [0:3];
  logic        m_wen [0:3];
  logic [11:0] m_addr [0:3];
  logic [63:0] m_wd [0:3];
  int          m_n;

  typedef struct {
    string       nm;
    logic [63:0] act;
    logic [63:0] exp;
  } lit_t;
  lit_t lit_q[$];

  int checks = 0, failures = 0;
  int lit_seen = 0;
  int cyc = 0, acc_cyc = 0, obs_lat = -1;
  int wen_pulses = 0, ren_pulses = 0;
  logic        rv_prev = 1'b0;
  logic [63:0] last_rd = '0, last_pc = '0;
  logic        last_redir = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process
  always @(negedge clk) begin
    chk("req_ready",  64'(req_ready_o),  64'(exp_ready));
    chk("csr_ren",    64'(csr_ren_o),    64'(exp_ren));
    chk("csr_wen",    64'(csr_wen_o),    64'(exp_wen));
    chk("csr_addr",   64'(csr_addr_o),   64'(exp_addr));
    chk("csr_wdata",  csr_wdata_o,       exp_wdata);
    chk("resp_valid", 64'(resp_valid_o), 64'(exp_rv));
    chk("resp_rd",    resp_rd_o,         exp_rd);
    chk("resp_redir", 64'(resp_redir_o), 64'(exp_redir));
    chk("resp_pc",    resp_pc_o,         exp_pc);
    chk("priv_cnt",   64'(priv_cnt_o),   64'(exp_cnt));
    while (lit_seen < lit_q.size()) begin
      chk(lit_q[lit_seen].nm, lit_q[lit_seen].act, lit_q[lit_seen].exp);
      lit_seen++;
    end
    if (rst_n && req_valid_i && req_ready_o) acc_cyc = cyc;
    if (resp_valid_o && !rv_prev) begin
      obs_lat    = cyc - acc_cyc;
      last_rd    = resp_rd_o;
      last_pc    = resp_pc_o;
      last_redir = resp_redir_o;
    end
    rv_prev = resp_valid_o;
    if (csr_wen_o) wen_pulses++;
    if (csr_ren_o) ren_pulses++;
    cyc++;
  end

  task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
    lit_t e;
    e.nm = nm; e.act = act; e.exp = exp;
    lit_q.push_back(e);
  endtask

  task automatic set_idle();
    exp_ready = 1'b1; exp_ren = 1'b0; exp_wen = 1'b0; exp_addr = '0; exp_wdata = '0;
    exp_rv = 1'b0; exp_rd = '0; exp_redir = 1'b0; exp_pc = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid_i = 1'b0; resp_ready_i = 1'($urandom); set_idle();
      @(posedge clk); #1;
    end
  endtask

  task automatic set_csr(input logic [11:0] a, input logic [63:0] d);
    bk_en = 1'b1; bk_addr = a; bk_data = d; ref_csr[a] = d;
    req_valid_i = 1'b0; set_idle();
    @(posedge clk); #1;
    bk_en = 1'b0;
  endtask

  task automatic scramble();
    req_valid_i  = 1'($urandom);
    req_op_i     = 3'($urandom);
    req_pc_i     = {$urandom, $urandom};
    req_csr_i    = 12'($urandom);
    req_rs1_i    = {$urandom, $urandom};
    req_rs1z_i   = 1'($urandom);
    resp_ready_i = 1'($urandom);
  endtask

  task automatic add_acc(input logic r, input logic w, input logic [11:0] a, input logic [63:0] d);
    m_ren[m_n] = r; m_wen[m_n] = w; m_addr[m_n] = a; m_wd[m_n] = d; m_n++;
  endtask

  // One op from presentation to handshake; abort_at>=0 pulls reset in that access cycle
  task automatic do_op(input logic [2:0] op, input logic [63:0] pc, input logic [11:0] csr,
                       input logic [63:0] rs1, input logic rs1z, input int hold, input int abort_at);
    logic [63:0] e_rd, e_pc, old, st;
    logic        e_redir, counted;
    e_rd = '0; e_pc = '0; e_redir = 1'b0; counted = 1'b1; m_n = 0;
    case (op)
      OP_CSRRW: begin
        old = ref_csr[csr];
        add_acc(1'b1, 1'b0, csr, 64'h0);
        add_acc(1'b0, 1'b1, csr, rs1);
        e_rd = old;
      end
      OP_CSRRS: begin
        old = ref_csr[csr];
        add_acc(1'b1, 1'b0, csr, 64'h0);
        if (!rs1z) add_acc(1'b0, 1'b1, csr, old | rs1);
        e_rd = old;
      end
      OP_ECALL: begin
        add_acc(1'b0, 1'b1, 12'h341, pc);
        add_acc(1'b0, 1'b1, 12'h342, 64'd11);
        add_acc(1'b1, 1'b0, 12'h305, 64'h0);
        e_redir = 1'b1; e_pc = ref_csr[12'h305];
      end
      OP_MRET: begin
        st = ref_csr[12'h300];
        add_acc(1'b1, 1'b0, 12'h341, 64'h0);
        add_acc(1'b1, 1'b0, 12'h300, 64'h0);
        add_acc(1'b0, 1'b1, 12'h300, (st & ~64'h1888) | 64'h80 | ((st >> 4) & 64'h8));
        e_redir = 1'b1; e_pc = ref_csr[12'h341];
      end
      default: counted = 1'b0;
    endcase

    req_valid_i = 1'b1; req_op_i = op; req_pc_i = pc; req_csr_i = csr;
    req_rs1_i = rs1; req_rs1z_i = rs1z; resp_ready_i = 1'($urandom); set_idle();
    @(posedge clk); #1;
    for (int i = 0; i < m_n; i++) begin
      scramble();
      if (i == abort_at) begin
        req_valid_i = 1'b0; rst_n = 1'b0; exp_cnt = '0; set_idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      exp_ready = 1'b0; exp_ren = m_ren[i]; exp_wen = m_wen[i]; exp_addr = m_addr[i];
      exp_wdata = m_wd[i]; exp_rv = 1'b0; exp_rd = '0; exp_redir = 1'b0; exp_pc = '0;
      if (m_wen[i]) ref_csr[m_addr[i]] = m_wd[i];
      @(posedge clk); #1;
    end
    for (int h = 0; h <= hold; h++) begin
      scramble();
      resp_ready_i = (h == hold);
      exp_ready = 1'b0; exp_ren = 1'b0; exp_wen = 1'b0; exp_addr = '0; exp_wdata = '0;
      exp_rv = 1'b1; exp_rd = e_rd; exp_redir = e_redir; exp_pc = e_pc;
      @(posedge clk); #1;
    end
`ifdef YSYX_22040895_PRIV_CNT_EN
    if (counted && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
`endif
    req_valid_i = 1'b0; set_idle();
  endtask

  initial begin
    logic [2:0]  op_tab [0:9];
    logic [11:0] csr_tab [0:4];
    int w0, r0;
    op_tab  = '{OP_ECALL, OP_MRET, OP_CSRRS, OP_CSRRS, OP_CSRRW, OP_CSRRW, OP_ECALL, OP_MRET, 3'b111, 3'b000};
    csr_tab = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342};
    set_idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    foreach (csr_tab[i]) set_csr(csr_tab[i], 64'h0);

    set_csr(12'h340, 64'h5);
    do_op(OP_CSRRW, 64'h0, 12'h340, 64'hA, 1'b0, 0, -1);
    lit("csrrw_rd", last_rd, 64'h5);
    lit("csrrw_redir", 64'(last_redir), 64'h0);
    lit("csrrw_lat", 64'(obs_lat), 64'd3);
    lit("csrrw_mem", csr_mem[12'h340], 64'hA);

    w0 = wen_pulses; r0 = ren_pulses;
    do_op(3'b111, 64'h0, 12'h300, 64'h0, 1'b0, 0, -1);
    lit("inv_lat", 64'(obs_lat), 64'd1);
    lit("inv_rd", last_rd, 64'h0);
    lit("inv_redir", 64'(last_redir), 64'h0);
    lit("inv_strobes", 64'(wen_pulses - w0 + ren_pulses - r0), 64'h0);
`ifdef YSYX_22040895_PRIV_CNT_EN
    lit("inv_cnt", 64'(priv_cnt_o), 64'd1);
`else
    lit("inv_cnt", 64'(priv_cnt_o), 64'd0);
`endif

    set_csr(12'h300, 64'h8);
    do_op(OP_CSRRS, 64'h0, 12'h300, 64'h80, 1'b0, 0, -1);
    lit("csrrs_rd", last_rd, 64'h8);
    lit("csrrs_mem", csr_mem[12'h300], 64'h88);
    lit("csrrs_lat", 64'(obs_lat), 64'd3);
    set_csr(12'h300, 64'h8);
    w0 = wen_pulses;
    do_op(OP_CSRRS, 64'h0, 12'h300, 64'h80, 1'b1, 0, -1);
    lit("csrrs_z_rd", last_rd, 64'h8);
    lit("csrrs_z_mem", csr_mem[12'h300], 64'h8);
    lit("csrrs_z_lat", 64'(obs_lat), 64'd2);
    lit("csrrs_z_wen", 64'(wen_pulses - w0), 64'd0);

    set_csr(12'h305, 64'h8000_0100);
    do_op(OP_ECALL, 64'h8000_0010, 12'h0, 64'h0, 1'b0, 0, -1);
    lit("ecall_mepc", csr_mem[12'h341], 64'h8000_0010);
    lit("ecall_mcause", csr_mem[12'h342], 64'd11);
    lit("ecall_redir", 64'(last_redir), 64'h1);
    lit("ecall_pc", last_pc, 64'h8000_0100);
    lit("ecall_lat", 64'(obs_lat), 64'd4);

    set_csr(12'h341, 64'h8000_0014);
    set_csr(12'h300, 64'h1880);
    do_op(OP_MRET, 64'h0, 12'h0, 64'h0, 1'b0, 1, -1);
    lit("mret_st_a", csr_mem[12'h300], 64'h88);
    lit("mret_pc", last_pc, 64'h8000_0014);
    lit("mret_lat", 64'(obs_lat), 64'd4);
    set_csr(12'h300, 64'h1800);
    do_op(OP_MRET, 64'h0, 12'h0, 64'h0, 1'b0, 0, -1);
    lit("mret_st_b", csr_mem[12'h300], 64'h80);

    set_csr(12'h340, 64'h77);
    w0 = wen_pulses;
    do_op(OP_CSRRW, 64'h0, 12'h340, 64'h99, 1'b0, 10, -1);
    lit("bp_rd", last_rd, 64'h77);
    lit("bp_wen", 64'(wen_pulses - w0), 64'd1);

    set_csr(12'h342, 64'h55);
    do_op(OP_ECALL, 64'h1234, 12'h0, 64'h0, 1'b0, 0, 1);
    lit("abort_mcause", csr_mem[12'h342], 64'h55);
    lit("abort_mepc", csr_mem[12'h341], 64'h1234);
    lit("abort_cnt", 64'(priv_cnt_o), 64'd0);
    idle(1);

    for (int k = 0; k < 150; k++) begin
      do_op(op_tab[$urandom_range(9, 0)], {$urandom, $urandom}, csr_tab[$urandom_range(4, 0)],
            {$urandom, $urandom}, 1'($urandom), $urandom_range(3, 0), -1);
      idle($urandom_range(2, 0));
    end

    idle(1);
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
